// File: rtl/alu_issue_pkg.sv
// Shared decode constants and types for the ALU issue stage.
package alu_issue_pkg;

    localparam int ALU_CTRL = 12;

    // One-hot ALU control bit positions.
    localparam int ADD_BIT  = 11;
    localparam int SUB_BIT  = 10;
    localparam int SLT_BIT  = 9;
    localparam int SLTU_BIT = 8;
    localparam int AND_BIT  = 7;
    localparam int NOR_BIT  = 6;
    localparam int OR_BIT   = 5;
    localparam int XOR_BIT  = 4;
    localparam int SLL_BIT  = 3;
    localparam int SRL_BIT  = 2;
    localparam int SRA_BIT  = 1;
    localparam int LUI_BIT  = 0;

    // Opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes.
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Operand source selects; ZERO is used for illegal encodings.
    typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS, SRC1_IMM} src1_sel_e;
    typedef enum logic [1:0] {SRC2_ZERO, SRC2_RT, SRC2_IMM} src2_sel_e;

    // Decoder result; imm_ext carries the shift amount for constant shifts.
    typedef struct packed {
        logic [ALU_CTRL-1:0] alu_control;
        src1_sel_e           src1_sel;
        src2_sel_e           src2_sel;
        logic [31:0]         imm_ext;
        logic [4:0]          rs_idx;
        logic [4:0]          rt_idx;
        logic [4:0]          dest;
        logic                illegal;
    } dec_t;

    // Register read with write-back bypass; r0 always reads zero.
    function automatic logic [31:0] fwd(input logic [4:0]  idx,
                                        input logic [31:0] rf_val,
                                        input logic        wb_valid,
                                        input logic [4:0]  wb_dest,
                                        input logic [31:0] wb_data);
        if (idx == 5'd0)
            return 32'd0;
        else if (wb_valid && wb_dest == idx)
            return wb_data;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu_decoder.sv
// Combinational instruction decoder: inst -> ALU control, operand selects, dest.
module alu_decoder
    import alu_issue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];

    // Decode; anything not explicitly matched stays illegal with zeroed fields.
    always_comb begin
        dec          = '0;
        dec.src1_sel = SRC1_ZERO;
        dec.src2_sel = SRC2_ZERO;
        dec.illegal  = 1'b1;
        dec.rs_idx   = inst[25:21];
        dec.rt_idx   = inst[20:16];
        case (op)
            OP_RTYPE: begin
                dec.illegal  = 1'b0;
                dec.src1_sel = SRC1_RS;
                dec.src2_sel = SRC2_RT;
                dec.dest     = inst[15:11];
                case (funct)
                    F_ADDU: dec.alu_control[ADD_BIT]  = 1'b1;
                    F_SUBU: dec.alu_control[SUB_BIT]  = 1'b1;
                    F_SLT:  dec.alu_control[SLT_BIT]  = 1'b1;
                    F_SLTU: dec.alu_control[SLTU_BIT] = 1'b1;
                    F_AND:  dec.alu_control[AND_BIT]  = 1'b1;
                    F_OR:   dec.alu_control[OR_BIT]   = 1'b1;
                    F_XOR:  dec.alu_control[XOR_BIT]  = 1'b1;
                    F_NOR:  dec.alu_control[NOR_BIT]  = 1'b1;
                    F_SLLV: dec.alu_control[SLL_BIT]  = 1'b1;
                    F_SRLV: dec.alu_control[SRL_BIT]  = 1'b1;
                    F_SRAV: dec.alu_control[SRA_BIT]  = 1'b1;
                    F_SLL, F_SRL, F_SRA: begin
                        // Constant shifts take the amount from the shamt field.
                        dec.src1_sel = SRC1_IMM;
                        dec.imm_ext  = {27'd0, inst[10:6]};
                        if (funct == F_SLL)      dec.alu_control[SLL_BIT] = 1'b1;
                        else if (funct == F_SRL) dec.alu_control[SRL_BIT] = 1'b1;
                        else                     dec.alu_control[SRA_BIT] = 1'b1;
                    end
                    default: begin
                        dec.illegal  = 1'b1;
                        dec.src1_sel = SRC1_ZERO;
                        dec.src2_sel = SRC2_ZERO;
                        dec.dest     = 5'd0;
                    end
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.illegal  = 1'b0;
                dec.src1_sel = SRC1_RS;
                dec.src2_sel = SRC2_IMM;
                dec.dest     = inst[20:16];
                // Arithmetic/compare immediates sign-extend, logical and LUI zero-extend.
                if (op == OP_ADDIU || op == OP_SLTI || op == OP_SLTIU)
                    dec.imm_ext = {{16{imm[15]}}, imm};
                else
                    dec.imm_ext = {16'd0, imm};
                case (op)
                    OP_ADDIU: dec.alu_control[ADD_BIT]  = 1'b1;
                    OP_SLTI:  dec.alu_control[SLT_BIT]  = 1'b1;
                    OP_SLTIU: dec.alu_control[SLTU_BIT] = 1'b1;
                    OP_ANDI:  dec.alu_control[AND_BIT]  = 1'b1;
                    OP_ORI:   dec.alu_control[OR_BIT]   = 1'b1;
                    OP_XORI:  dec.alu_control[XOR_BIT]  = 1'b1;
                    default:  dec.alu_control[LUI_BIT]  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: forwarding, single-slot issue register, issue counter.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         rs_value,
    input  logic [31:0]         rt_value,
    input  logic                wb_valid,
    input  logic [4:0]          wb_dest,
    input  logic [31:0]         wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_CTRL-1:0] alu_control,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    output logic [4:0]          out_dest,
    output logic [31:0]         out_pc,
    output logic                out_illegal,
    output logic [31:0]         issue_count
);

    dec_t        dec;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
    logic [31:0] src1_d;
    logic [31:0] src2_d;
    logic        capture;
    logic        consume;

    alu_decoder u_dec (
        .inst (in_inst),
        .dec  (dec)
    );

    assign rs_fwd   = fwd(dec.rs_idx, rs_value, wb_valid, wb_dest, wb_data);
    assign rt_fwd   = fwd(dec.rt_idx, rt_value, wb_valid, wb_dest, wb_data);
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Operand muxes driven by the decoder selects.
    always_comb begin
        src1_d = 32'd0;
        src2_d = 32'd0;
        case (dec.src1_sel)
            SRC1_RS:  src1_d = rs_fwd;
            SRC1_IMM: src1_d = dec.imm_ext;
            default:  src1_d = 32'd0;
        endcase
        case (dec.src2_sel)
            SRC2_RT:  src2_d = rt_fwd;
            SRC2_IMM: src2_d = dec.imm_ext;
            default:  src2_d = 32'd0;
        endcase
    end

    // Issue slot: load on capture, drop valid on consume-only, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            alu_src1    <= 32'd0;
            alu_src2    <= 32'd0;
            out_dest    <= 5'd0;
            out_pc      <= 32'd0;
            out_illegal <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            alu_control <= dec.alu_control;
            alu_src1    <= src1_d;
            alu_src2    <= src2_d;
            out_dest    <= dec.dest;
            out_pc      <= in_pc;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Issued-instruction counter, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            issue_count <= 32'd0;
        else if (consume)
            issue_count <= issue_count + 32'd1;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic vs. a reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0, in_pc = '0, rs_value = '0, rt_value = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2, out_pc, issue_count;
    logic [4:0]  out_dest;
    logic        out_illegal;

    int n_cmp = 0;
    int n_fail = 0;

    logic [5:0] legal_f [14] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs_value(rs_value), .rt_value(rt_value),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .out_dest(out_dest),
        .out_pc(out_pc), .out_illegal(out_illegal), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // {valid, illegal, ctrl, src1, src2, dest, pc}
    function automatic logic [114:0] mk(input logic v, ill, input logic [11:0] c,
                                        input logic [31:0] s1, s2, input logic [4:0] d, input logic [31:0] pc);
        return {v, ill, c, s1, s2, d, pc};
    endfunction

    function automatic logic [114:0] snap();
        return {out_valid, out_illegal, alu_control, alu_src1, alu_src2, out_dest, out_pc};
    endfunction

    // Reference decode straight from the instruction-set table.
    task automatic ref_dec(input logic [31:0] inst, rsv, rtv, input logic wbv, input logic [4:0] wbd,
                           input logic [31:0] wbdat, output logic [11:0] c, output logic [31:0] s1, s2,
                           output logic [4:0] dst, output logic ill);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, sa, sx, zx;
        op = inst[31:26]; fn = inst[5:0];
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
        a  = (rs == 0) ? 32'd0 : (wbv && wbd == rs) ? wbdat : rsv;
        b  = (rt == 0) ? 32'd0 : (wbv && wbd == rt) ? wbdat : rtv;
        sa = {27'd0, inst[10:6]};
        sx = {{16{inst[15]}}, inst[15:0]};
        zx = {16'd0, inst[15:0]};
        c = 0; s1 = 0; s2 = 0; dst = 0; ill = 1;
        if (op == 6'h00) begin
            case (fn)
                6'h21: {c, s1, s2} = {12'h800, a, b};
                6'h23: {c, s1, s2} = {12'h400, a, b};
                6'h2A: {c, s1, s2} = {12'h200, a, b};
                6'h2B: {c, s1, s2} = {12'h100, a, b};
                6'h24: {c, s1, s2} = {12'h080, a, b};
                6'h27: {c, s1, s2} = {12'h040, a, b};
                6'h25: {c, s1, s2} = {12'h020, a, b};
                6'h26: {c, s1, s2} = {12'h010, a, b};
                6'h00: {c, s1, s2} = {12'h008, sa, b};
                6'h02: {c, s1, s2} = {12'h004, sa, b};
                6'h03: {c, s1, s2} = {12'h002, sa, b};
                6'h04: {c, s1, s2} = {12'h008, a, b};
                6'h06: {c, s1, s2} = {12'h004, a, b};
                6'h07: {c, s1, s2} = {12'h002, a, b};
                default: ;
            endcase
            if (c != 0) begin ill = 0; dst = rd; end
        end else begin
            case (op)
                6'h09: {c, s1, s2} = {12'h800, a, sx};
                6'h0A: {c, s1, s2} = {12'h200, a, sx};
                6'h0B: {c, s1, s2} = {12'h100, a, sx};
                6'h0C: {c, s1, s2} = {12'h080, a, zx};
                6'h0D: {c, s1, s2} = {12'h020, a, zx};
                6'h0E: {c, s1, s2} = {12'h010, a, zx};
                6'h0F: {c, s1, s2} = {12'h001, a, zx};
                default: ;
            endcase
            if (c != 0) begin ill = 0; dst = rt; end
        end
    endtask

    // Present one instruction with out_ready=1 for one edge, then idle the input.
    task automatic issue(input logic [31:0] inst, pc, rsv, rtv, input logic wbv,
                         input logic [4:0] wbd, input logic [31:0] wbdat);
        in_valid = 1; in_inst = inst; in_pc = pc; rs_value = rsv; rt_value = rtv;
        wb_valid = wbv; wb_dest = wbd; wb_data = wbdat; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; wb_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({snap(), issue_count, in_ready} !== {mk(0, 0, 0, 0, 0, 0, 0), 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: got %h/%h/%b expected all zero, in_ready 1", snap(), issue_count, in_ready);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_addu();
        issue(r_inst(1, 2, 3, 0, 6'h21), 32'h100, 5, 7, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h800, 5, 7, 3, 32'h100)) begin
            n_fail++; $display("FAIL addu: got %h expected %h", snap(), mk(1, 0, 12'h800, 5, 7, 3, 32'h100));
        end
    endtask

    task automatic test_shifts();
        issue(r_inst(0, 2, 4, 8, 6'h00), 32'h104, 32'h99, 1, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h008, 8, 1, 4, 32'h104)) begin
            n_fail++; $display("FAIL sll: got %h expected %h", snap(), mk(1, 0, 12'h008, 8, 1, 4, 32'h104));
        end
        issue(r_inst(1, 2, 5, 0, 6'h07), 32'h108, 32'h25, 32'hF000_0000, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h002, 32'h25, 32'hF000_0000, 5, 32'h108)) begin
            n_fail++; $display("FAIL srav: got %h expected %h", snap(), mk(1, 0, 12'h002, 32'h25, 32'hF000_0000, 5, 32'h108));
        end
    endtask

    task automatic test_imm();
        issue(i_inst(6'h0D, 1, 6, 16'h8001), 32'h10C, 32'h3, 32'h77, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h020, 3, 32'h0000_8001, 6, 32'h10C)) begin
            n_fail++; $display("FAIL ori: got %h expected %h", snap(), mk(1, 0, 12'h020, 3, 32'h0000_8001, 6, 32'h10C));
        end
        issue(i_inst(6'h0A, 1, 7, 16'h8001), 32'h110, 32'h3, 32'h77, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h200, 3, 32'hFFFF_8001, 7, 32'h110)) begin
            n_fail++; $display("FAIL slti: got %h expected %h", snap(), mk(1, 0, 12'h200, 3, 32'hFFFF_8001, 7, 32'h110));
        end
        issue(i_inst(6'h0F, 0, 8, 16'h1234), 32'h114, 32'h3, 32'h77, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h001, 0, 32'h1234, 8, 32'h114)) begin
            n_fail++; $display("FAIL lui: got %h expected %h", snap(), mk(1, 0, 12'h001, 0, 32'h1234, 8, 32'h114));
        end
    endtask

    task automatic test_forwarding();
        issue(r_inst(1, 2, 3, 0, 6'h21), 32'h118, 5, 7, 1, 1, 32'hAA);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h800, 32'hAA, 7, 3, 32'h118)) begin
            n_fail++; $display("FAIL fwd_rs: got %h expected %h", snap(), mk(1, 0, 12'h800, 32'hAA, 7, 3, 32'h118));
        end
        issue(r_inst(0, 2, 3, 0, 6'h21), 32'h11C, 5, 7, 1, 0, 32'hAA);
        n_cmp++;
        if (snap() !== mk(1, 0, 12'h800, 0, 7, 3, 32'h11C)) begin
            n_fail++; $display("FAIL fwd_r0: got %h expected %h", snap(), mk(1, 0, 12'h800, 0, 7, 3, 32'h11C));
        end
    endtask

    task automatic test_illegal();
        issue(i_inst(6'h3F, 1, 2, 16'hFFFF), 32'h120, 5, 7, 0, 0, 0);
        n_cmp++;
        if (snap() !== mk(1, 1, 0, 0, 0, 0, 32'h120)) begin
            n_fail++; $display("FAIL illegal: got %h expected %h", snap(), mk(1, 1, 0, 0, 0, 0, 32'h120));
        end
    endtask

    task automatic test_back_to_back();
        logic [114:0] exp_a, exp_b;
        exp_a = mk(1, 0, 12'h400, 9, 4, 10, 32'h200);
        exp_b = mk(1, 0, 12'h010, 6, 32'h0F0F, 11, 32'h204);
        do_reset();
        issue(r_inst(1, 2, 10, 0, 6'h23), 32'h200, 9, 4, 0, 0, 0);
        in_valid = 1; in_inst = i_inst(6'h0E, 1, 11, 16'h0F0F); in_pc = 32'h204;
        rs_value = 6; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready: got %b expected 0 (cycle %0d)", in_ready, i);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({snap(), issue_count} !== {exp_a, 32'd0}) begin
                n_fail++; $display("FAIL stall_hold: got %h/%0d expected %h/0", snap(), issue_count, exp_a);
            end
        end
        out_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({snap(), issue_count} !== {exp_b, 32'd1}) begin
            n_fail++; $display("FAIL release_load: got %h/%0d expected %h/1", snap(), issue_count, exp_b);
        end
        // Stall again, then reset asynchronously mid-cycle.
        in_valid = 0; out_ready = 0;
        @(posedge clk); #2;
        reset = 1;
        #1;
        n_cmp++;
        if ({out_valid, issue_count, alu_control, out_pc, in_ready} !== {1'b0, 32'd0, 12'd0, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset: got v=%b cnt=%0d ctrl=%h pc=%h rdy=%b expected 0/0/0/0/1",
                               out_valid, issue_count, alu_control, out_pc, in_ready);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_random();
        logic        m_valid, m_ill, e_ill, exp_rdy, iv, orr;
        logic [11:0] m_c, e_c;
        logic [31:0] m_s1, m_s2, m_pc, m_count, e_s1, e_s2, inst;
        logic [4:0]  m_d, e_d;
        int          k;
        do_reset();
        m_valid = 0; m_ill = 0; m_c = 0; m_s1 = 0; m_s2 = 0; m_pc = 0; m_d = 0; m_count = 0;
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5)
                inst = r_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
                              (k == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 13)]);
            else if (k < 9)
                inst = i_inst(6'($urandom_range(9, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            else
                inst = $urandom;
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            in_valid = iv; in_inst = inst; in_pc = $urandom;
            rs_value = $urandom; rt_value = $urandom;
            wb_valid = $urandom_range(0, 1); wb_dest = $urandom_range(0, 3); wb_data = $urandom;
            out_ready = orr;
            #1;
            exp_rdy = !m_valid || orr;
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy);
            end
            ref_dec(inst, rs_value, rt_value, wb_valid, wb_dest, wb_data, e_c, e_s1, e_s2, e_d, e_ill);
            @(posedge clk);
            if (m_valid && orr) m_count++;
            if (iv && exp_rdy) begin
                m_valid = 1; m_c = e_c; m_s1 = e_s1; m_s2 = e_s2; m_d = e_d; m_ill = e_ill; m_pc = in_pc;
            end else if (orr) begin
                m_valid = 0;
            end
            #1;
            n_cmp++;
            if ({snap(), issue_count} !== {mk(m_valid, m_ill, m_c, m_s1, m_s2, m_d, m_pc), m_count}) begin
                n_fail++;
                $display("FAIL rnd_out[%0d] inst=%h: got %h/%0d expected %h/%0d", i, inst, snap(), issue_count,
                         mk(m_valid, m_ill, m_c, m_s1, m_s2, m_d, m_pc), m_count);
            end
        end
        in_valid = 0; wb_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addu();
        test_shifts();
        test_imm();
        test_forwarding();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue pipeline stage directly upstream of the 12-operation ALU in the on-board MIPS CPU. Accepts a fetched instruction plus register-file read values, decodes the instruction into the ALU's one-hot 12-bit control word and its two operands, and applies write-back forwarding. It holds the result in a registered valid/ready pipeline slot that the execute stage consumes. It also flags unsupported opcodes and counts issued instructions.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register indices).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- rs_value  in  32  register-file read of inst[25:21]
- rt_value  in  32  register-file read of inst[20:16]
- wb_valid  in  1  write-back port active
- wb_dest  in  5  write-back register index
- wb_data  in  32  write-back value
- out_valid  out  1  issue slot holds a valid instruction
- out_ready  in  1  execute stage consumes this cycle
- alu_control  out  12  one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui
- alu_src1  out  32  operand 1; shift amount in bits [4:0] for shifts
- alu_src2  out  32  operand 2; shifted value for shifts, imm in [15:0] for lui
- out_dest  out  5  destination register (0 = no write)
- out_pc  out  32  registered in_pc
- out_illegal  out  1  instruction not in supported set
- issue_count  out  32  instructions issued to execute

## Operation
- Supported R-type (op 0), by funct: ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x00, SRL 0x02, SRA 0x03, SLLV 0x04, SRLV 0x06, SRAV 0x07. Dest = rd = inst[15:11].
- Supported I-type: ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B (imm sign-extended); ANDI 0x0C, ORI 0x0D, XORI 0x0E (imm zero-extended); LUI 0x0F. Dest = rt.
- Operands: src1 = fwd(rs), except SLL/SRL/SRA where src1 = {27'd0, inst[10:6]}. src2 = fwd(rt) for R-type, extended imm for I-type; LUI src2 = {16'd0, imm}.
- fwd(r): 0 if index r == 0; else wb_data if wb_valid && wb_dest == r; else the register-file value.
- Unsupported encoding: alu_control = 0, out_dest = 0, src1 = src2 = 0, out_illegal = 1; the instruction still flows through the handshake.
- issue_count increments by 1 on each out_valid && out_ready cycle. It wraps 0xFFFFFFFF -> 0.

## Timing
- in_ready = !out_valid || out_ready (combinational; single slot, no skid buffer).
- Capture on in_valid && in_ready: all outputs update on that edge. Latency is 1 cycle from accept to out_valid.
- out_valid clears on out_ready when there is no simultaneous capture. Simultaneous consume and capture keeps out_valid = 1 and loads the new instruction.
- While out_valid && !out_ready, all outputs hold stable. A write-back occurring during the stall is not re-applied; upstream owns that hazard.
- Reset, asynchronous at any time including mid-stall, forces: out_valid 0, alu_control 0, alu_src1/src2 0, out_dest 0, out_pc 0, out_illegal 0, issue_count 0. in_ready is 1 after reset.

## Structure
- Shared package holds: opcode/funct constants; ALU one-hot bit positions (ADD_BIT = 11 … LUI_BIT = 0); the 12-bit ALU_CTRL width.
- One combinational sub-module, alu_decoder, maps inst -> {alu_control, src1_sel, src2_sel, imm_ext, dest, illegal}.
- The top level holds forwarding muxes, the issue register, handshake logic and the counter.

## Test plan
- ADDU rd=3 rs=1 rt=2, rs_value 5, rt_value 7 -> one cycle later out_valid=1, alu_control=0x800, src1=5, src2=7, out_dest=3.
- SLL rd=4 rt=2 sa=8, rt_value 0x1 -> alu_control=0x008, src1=8, src2=1. SRAV with rs_value 0x25 -> src1=0x25 (the ALU uses [4:0]).
- ORI imm=0x8001 -> src2=0x00008001. SLTI imm=0x8001 -> src2=0xFFFF8001, alu_control=0x200. LUI imm=0x1234 -> alu_control=0x001, src2=0x1234.
- Forwarding: wb_valid=1, wb_dest=1, wb_data=0xAA while capturing ADDU with rs=1 -> src1=0xAA. Same with wb_dest=0 and rs=0 -> src1=0.
- Backpressure: out_ready=0 for 3 cycles -> in_ready=0 and outputs held. Then out_ready=1 with in_valid=1 -> the new instruction loads with no bubble, and issue_count increments by 1.
- Opcode 0x3F -> out_illegal=1, alu_control=0. Assert reset mid-stall -> out_valid=0 and issue_count=0 immediately, without waiting for a clock edge.
